// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding, parity mode
// encoding and small parity helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } parity_mode_e;

   // Reserved encoding sends no parity bit, same as PAR_NONE.
   function automatic logic parity_enabled(input parity_mode_e mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Narrower words are zero-extended by the caller; zeros do not change the XOR.
   function automatic logic parity_bit(input logic [7:0] data, input parity_mode_e mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: a down-counter that reloads at terminal count and emits a
// one-cycle tick every BAUD_DIV cycles. clear restarts a full period so the
// first bit of a frame is exactly BAUD_DIV cycles long.
module uart_baud_gen #(
   parameter int CLOCK_SPEED = 50_000_000,
   parameter int BAUD_RATE   = 115_200
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int BAUD_DIV = CLOCK_SPEED / BAUD_RATE;

   if (BAUD_DIV < 2) begin : g_bad_div
      $error("uart_baud_gen: CLOCK_SPEED/BAUD_RATE must be at least 2");
   end

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: restart on clear, reload at terminal count, otherwise count down.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = RELOAD;
      end else if (cnt_q == '0) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..8 data bits LSB first, optional even/odd
// parity, one or two stop bits. Frame configuration is latched on the
// accepting handshake so the source may change its inputs mid-frame.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, in_ready=1, waiting for in_valid
// ST_START  | start bit (tx=0) for one bit period
// ST_DATA   | data bits, LSB first, bit_cnt counts down to 0
// ST_PARITY | parity bit for one bit period (only if enabled)
// ST_STOP   | stop bits (tx=1), bit_cnt counts down to 0
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLOCK_SPEED = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BAUD_DIV = CLOCK_SPEED / BAUD_RATE;

   if (BAUD_DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: CLOCK_SPEED/BAUD_RATE must be at least 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..8");
   end

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
   logic                 two_stop_q, two_stop_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 transfer;
   logic                 tick;

   assign transfer = in_valid && (state_q == ST_IDLE);

   uart_baud_gen #(
      .CLOCK_SPEED (CLOCK_SPEED),
      .BAUD_RATE   (BAUD_RATE)
   ) u_baud_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (transfer),
      .tick  (tick)
   );

   // Next-state, capture and line-level logic; tx_d is the level for the next cycle.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      two_stop_d = two_stop_q;
      bit_cnt_d  = bit_cnt_q;
      tx_d       = tx_q;
      unique case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (in_valid) begin
               state_d    = ST_START;
               data_d     = in_data;
               par_en_d   = parity_enabled(parity_mode_e'(parity_mode));
               par_bit_d  = parity_bit(8'(in_data), parity_mode_e'(parity_mode));
               two_stop_d = two_stop;
               tx_d       = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_cnt_d = LAST_DATA;
               tx_d      = data_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt_q == 3'd0) begin
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d   = ST_STOP;
                     bit_cnt_d = {2'b00, two_stop_q};
                     tx_d      = 1'b1;
                  end
               end else begin
                  // Shift so the bit on the line is always data_q[0].
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  data_d    = data_q >> 1;
                  tx_d      = data_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d   = ST_STOP;
               bit_cnt_d = {2'b00, two_stop_q};
               tx_d      = 1'b1;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (bit_cnt_q == 3'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State and captured-frame registers; reset idles the line high at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         bit_cnt_q  <= 3'd0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         two_stop_q <= two_stop_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign in_ready = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);
   // Last cycle of the last stop bit: decoded from registers only.
   assign done     = (state_q == ST_STOP) && (bit_cnt_q == 3'd0) && tick;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit and a 5-bit instance at BAUD_DIV=4. Each
// accepted word pushes its expected per-cycle line trace onto a queue; a
// negedge monitor pops and compares tx/done/in_ready/busy every cycle.
module tb_uart_tx_cfg;

   localparam int CS = 1000;
   localparam int BR = 250;
   localparam int BD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid8 = 1'b0;
   logic       in_valid5 = 1'b0;
   logic [7:0] in_data8 = '0;
   logic [4:0] in_data5 = '0;
   logic [1:0] parity_mode = 2'b00;
   logic       two_stop = 1'b0;
   logic       in_ready8, tx8, busy8, done8;
   logic       in_ready5, tx5, busy5, done5;

   typedef struct packed {
      logic tx;
      logic done;
      logic ready;
      logic busy;
   } rec_t;

   rec_t q8[$];
   rec_t q5[$];
   rec_t r8, r5;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc8     = 0;
   int   cyc5     = 0;
   logic [7:0] word;

   always #5 clk = ~clk;

   uart_tx_cfg #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .DATA_BITS(8)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid8),
      .in_ready    (in_ready8),
      .in_data     (in_data8),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .tx          (tx8),
      .busy        (busy8),
      .done        (done8)
   );

   uart_tx_cfg #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .DATA_BITS(5)) dut5 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid5),
      .in_ready    (in_ready5),
      .in_data     (in_data5),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .tx          (tx5),
      .busy        (busy5),
      .done        (done5)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected frame: start, data LSB first, optional parity, stop bit(s), BD cycles each.
   task automatic push_frame(input bit is5, input logic [7:0] d, input logic [1:0] mode, input bit two);
      logic bits[$];
      int   nb;
      logic p;
      rec_t r;
      nb = is5 ? 5 : 8;
      p  = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         bits.push_back(d[i]);
         p = p ^ d[i];
      end
      if (mode == 2'b01) bits.push_back(p);
      else if (mode == 2'b10) bits.push_back(~p);
      bits.push_back(1'b1);
      if (two) bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++) begin
         for (int c = 0; c < BD; c++) begin
            r.tx    = bits[b];
            r.done  = (b == bits.size() - 1) && (c == BD - 1);
            r.ready = 1'b0;
            r.busy  = 1'b1;
            if (is5) q5.push_back(r);
            else q8.push_back(r);
         end
      end
   endtask

   task automatic push_gap8();
      rec_t r;
      r.tx = 1'b1; r.done = 1'b0; r.ready = 1'b1; r.busy = 1'b0;
      q8.push_back(r);
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (((q8.size() != 0) || (q5.size() != 0)) && (i < 500)) begin
         @(negedge clk);
         i++;
      end
      check_val("scoreboard drained", q8.size() + q5.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Offer one word; after acceptance scramble every input to prove it was captured.
   task automatic send8(input logic [7:0] d, input logic [1:0] mode, input bit two);
      @(negedge clk);
      check_val("in_ready8 before send", in_ready8, 1);
      in_valid8 = 1'b1; in_data8 = d; parity_mode = mode; two_stop = two;
      @(posedge clk);
      push_frame(1'b0, d, mode, two);
      @(negedge clk);
      in_valid8 = 1'b0; in_data8 = ~d; parity_mode = ~mode; two_stop = ~two;
      wait_drain();
   endtask

   task automatic send5(input logic [4:0] d, input logic [1:0] mode, input bit two);
      @(negedge clk);
      check_val("in_ready5 before send", in_ready5, 1);
      in_valid5 = 1'b1; in_data5 = d; parity_mode = mode; two_stop = two;
      @(posedge clk);
      push_frame(1'b1, {3'b000, d}, mode, two);
      @(negedge clk);
      in_valid5 = 1'b0; in_data5 = ~d; parity_mode = ~mode; two_stop = ~two;
      wait_drain();
   endtask

   // Per-cycle comparison of both instances against their expected traces.
   always @(negedge clk) begin
      if (q8.size() > 0) begin
         r8 = q8.pop_front();
         cyc8++;
         check_val($sformatf("tx8 c%0d", cyc8), tx8, r8.tx);
         check_val($sformatf("done8 c%0d", cyc8), done8, r8.done);
         check_val($sformatf("in_ready8 c%0d", cyc8), in_ready8, r8.ready);
         check_val($sformatf("busy8 c%0d", cyc8), busy8, r8.busy);
      end
      if (q5.size() > 0) begin
         r5 = q5.pop_front();
         cyc5++;
         check_val($sformatf("tx5 c%0d", cyc5), tx5, r5.tx);
         check_val($sformatf("done5 c%0d", cyc5), done5, r5.done);
         check_val($sformatf("in_ready5 c%0d", cyc5), in_ready5, r5.ready);
         check_val($sformatf("busy5 c%0d", cyc5), busy5, r5.busy);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_val("reset tx8", tx8, 1);
      check_val("reset in_ready8", in_ready8, 1);
      check_val("reset busy8", busy8, 0);
      check_val("reset done8", done8, 0);
      check_val("reset tx5", tx5, 1);
      check_val("reset in_ready5", in_ready5, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      send8(8'hA5, 2'b00, 1'b0);
      send8(8'h07, 2'b01, 1'b0);
      send8(8'h07, 2'b10, 1'b0);
      send8(8'h00, 2'b01, 1'b0);
      send8(8'h3C, 2'b01, 1'b1);
      send8(8'hC3, 2'b11, 1'b0);
      send8(8'h80, 2'b10, 1'b1);

      // Back-to-back with in_valid held high: one IDLE cycle between frames.
      @(negedge clk);
      in_valid8 = 1'b1; in_data8 = 8'h11; parity_mode = 2'b00; two_stop = 1'b0;
      @(posedge clk);
      push_frame(1'b0, 8'h11, 2'b00, 1'b0);
      push_gap8();
      push_frame(1'b0, 8'h22, 2'b00, 1'b0);
      @(negedge clk);
      in_data8 = 8'h22;
      repeat (40) @(negedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      wait_drain();

      // Reset during the third data bit.
      word = 8'hFB;
      @(negedge clk);
      in_valid8 = 1'b1; in_data8 = word; parity_mode = 2'b00; two_stop = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (13) @(negedge clk);
      check_val("tx8 data bit2 before reset", tx8, word[2]);
      check_val("busy8 before reset", busy8, 1);
      #2 rst = 1'b1;
      #1;
      check_val("abort tx8", tx8, 1);
      check_val("abort in_ready8", in_ready8, 1);
      check_val("abort busy8", busy8, 0);
      check_val("abort done8", done8, 0);
      repeat (3) begin
         @(negedge clk);
         check_val("abort no done8", done8, 0);
         check_val("abort tx8 held", tx8, 1);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send8(8'h5A, 2'b00, 1'b0);

      send5(5'h1F, 2'b10, 1'b0);
      send5(5'h0A, 2'b01, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_SPEED, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..8.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  a word is offered on in_data.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port in_data  input  DATA_BITS  payload word.
REQ-009 SHALL have port parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
REQ-010 SHALL have port two_stop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress (any state other than IDLE).
REQ-013 SHALL have port done  output  1  single-cycle pulse on the last cycle of a frame.

Function
REQ-014 SHALL derive BAUD_DIV = floor(CLOCK_SPEED/BAUD_RATE); elaboration SHALL fail if BAUD_DIV < 2 or DATA_BITS outside 5..8.
REQ-015 SHALL size the bit-period counter as $clog2(BAUD_DIV) bits; every transmitted bit lasts exactly BAUD_DIV cycles.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 in_ready SHALL be 1 exactly when state is IDLE; a transfer occurs on a cycle with in_valid && in_ready.
REQ-018 On transfer, SHALL capture in_data, parity_mode and two_stop into internal registers; later changes to these inputs SHALL not affect the frame in progress.
REQ-019 Transitions: IDLE->START on transfer; START->DATA after BAUD_DIV cycles; DATA->PARITY (parity enabled) or STOP after DATA_BITS bit periods; PARITY->STOP after one bit period; STOP->IDLE after 1 or 2 bit periods.
REQ-020 tx SHALL be 1 in IDLE and STOP, 0 in START, captured data bit in DATA (LSB first), and the parity bit in PARITY.
REQ-021 Parity bit SHALL be XOR of captured data bits for even, its complement for odd.
REQ-022 done SHALL be 1 only in the final cycle of the final stop bit; state is IDLE on the following cycle.
REQ-023 Frame length SHALL be BAUD_DIV*(1+DATA_BITS+P+S) cycles from first START cycle, P in {0,1}, S in {1,2}.
REQ-024 Back-to-back: with in_valid held high, the next START SHALL begin two cycles after done (one IDLE cycle of tx=1 follows the stop bits).
REQ-025 in_valid while in_ready=0 SHALL be ignored; the source holds the word until transfer.

Reset
REQ-026 While rst=1, SHALL force tx=1, in_ready=1, busy=0, done=0, state=IDLE, counters and captured registers to zero.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 in the same cycle, asynchronously) with no done pulse.

Structure
REQ-028 SHALL place the state enum and the parity_mode encoding (typedef enum, 2 bits) in shared package uart_pkg.
REQ-029 SHALL instantiate sub-module uart_baud_gen (parameters CLOCK_SPEED, BAUD_RATE; inputs clk, rst, clear; output tick one cycle per BAUD_DIV), cleared on transfer.

Verification (CLOCK_SPEED=1000, BAUD_RATE=250 -> BAUD_DIV=4 unless stated)
REQ-030 SHALL verify 0xA5, none, one stop -> tx 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done at cycle 40; in_ready=0 throughout.
REQ-031 SHALL verify 0x07 even -> parity bit 1; 0x07 odd -> parity bit 0; 0x00 even -> 0; frame 40 cycles + 4.
REQ-032 SHALL verify 0x3C even, two stop -> stop high 8 cycles, done at cycle 48; in_data changed mid-frame has no effect.
REQ-033 SHALL verify in_valid held high with words 0x11 then 0x22 -> second start bit two cycles after first done; both frames bit-exact.
REQ-034 SHALL verify rst pulse in the 3rd data bit -> tx=1 same cycle, in_ready=1, no done; next frame 0x5A transmits correctly.
REQ-035 SHALL verify DATA_BITS=5 instance, 0x1F, odd -> 5 ones, parity 0, one stop, done at cycle 32.
